// File: rtl/bnn_binarize_pack.sv
// BNN neuron back end: accumulates NCHUNK popcounts per neuron, thresholds each sum to a
// sign bit and packs VWIDTH sign bits into one vector handed downstream with valid/ready.
module bnn_binarize_pack #(
    parameter int VWIDTH = 8,
    parameter int CWIDTH = 4,
    parameter int NCHUNK = 4,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CWIDTH-1:0] cnt_i,
    input  logic              cnt_valid,
    output logic              cnt_ready,
    input  logic [AWIDTH-1:0] thr_i,
    output logic [VWIDTH-1:0] vec_o,
    output logic              vec_valid,
    input  logic              vec_ready
);

    localparam int CTR_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W = (VWIDTH > 1) ? $clog2(VWIDTH) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VWIDTH - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   acc_q, acc_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VWIDTH-1:0]   pack_q, pack_d;
    logic [VWIDTH-1:0]   vec_q, vec_d;

    logic                accept;
    logic [AWIDTH:0]     sum;
    logic                sign_bit;
    logic [VWIDTH-1:0]   pack_with_bit;

    // Ready is forced low during reset so no chunk is taken while state is being cleared.
    assign cnt_ready = (state_q == ST_ACC) && !rst;
    assign vec_valid = (state_q == ST_FULL);
    assign vec_o     = vec_q;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        ctr_d         = ctr_q;
        idx_d         = idx_q;
        pack_d        = pack_q;
        vec_d         = vec_q;
        accept        = cnt_valid && cnt_ready;
        // One extra bit so an out-of-range count still compares correctly against thr_i.
        sum           = {1'b0, acc_q} + (AWIDTH + 1)'(cnt_i);
        sign_bit      = (sum >= {1'b0, thr_i});
        pack_with_bit = pack_q;
        pack_with_bit[idx_q] = sign_bit;

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (ctr_q == CTR_LAST) begin
                        acc_d = '0;
                        ctr_d = '0;
                        if (idx_q == IDX_LAST) begin
                            vec_d   = pack_with_bit;
                            pack_d  = '0;
                            idx_d   = '0;
                            state_d = ST_FULL;
                        end else begin
                            pack_d = pack_with_bit;
                            idx_d  = idx_q + IDX_W'(1);
                        end
                    end else begin
                        acc_d = sum[AWIDTH-1:0];
                        ctr_d = ctr_q + CTR_W'(1);
                    end
                end
            end
            ST_FULL: begin
                if (vec_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            ctr_q   <= '0;
            idx_q   <= '0;
            pack_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            pack_q  <= pack_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_bnn_binarize_pack.sv
// Randomized bench for bnn_binarize_pack: a neuron-level reference model fills a queue
// of expected vectors, and a monitor checks every presented vector against it.
`timescale 1ns/1ps
module tb_bnn_binarize_pack;

    localparam int VW  = 8;
    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt_i = '0;
    logic       cnt_valid = 1'b0;
    logic       cnt_ready;
    logic [5:0] thr_i = '0;
    logic [7:0] vec_o;
    logic       vec_valid;
    logic       vec_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic [7:0] last_vec = '0;

    int         chunk_q[$];
    bit         bits_q[$];
    logic [7:0] exp_q[$];

    bnn_binarize_pack #(.VWIDTH(8), .CWIDTH(4), .NCHUNK(4), .AWIDTH(6)) dut (
        .clk(clk), .rst(rst), .cnt_i(cnt_i), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .thr_i(thr_i), .vec_o(vec_o), .vec_valid(vec_valid), .vec_ready(vec_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a neuron fires when the plain sum of its chunks reaches its threshold.
    task automatic model_accept(input int c, input int t);
        logic [7:0] v;
        int s;
        chunk_q.push_back(c);
        if (chunk_q.size() == NCH) begin
            s = 0;
            foreach (chunk_q[i]) s += chunk_q[i];
            bits_q.push_back(s >= t);
            chunk_q.delete();
            if (bits_q.size() == VW) begin
                v = '0;
                foreach (bits_q[i]) v[i] = bits_q[i];
                exp_q.push_back(v);
                bits_q.delete();
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       vec_ready = 1'b1;
                1:       vec_ready = 1'b0;
                default: vec_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: while a vector is presented it must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && vec_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_vec: got %0h with no expected vector", vec_o);
                end else begin
                    chk("vec_o", vec_o, exp_q[0]);
                    chk("cnt_ready_in_full", cnt_ready, 1'b0);
                    if (vec_ready) begin
                        last_vec = vec_o;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input int c, input int t, input bit bub);
        bit done;
        int n;
        done = 1'b0;
        if (bub) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                cnt_valid = 1'b0;
                cnt_i = 4'($urandom);
            end
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            cnt_valid = 1'b1;
            cnt_i = 4'(c);
            thr_i = 6'(t);
            #1;
            if (cnt_ready) begin
                @(posedge clk);
                model_accept(c, t);
                done = 1'b1;
                #1;
                cnt_valid = 1'b0;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: cnt_ready stayed 0 got 0 expected 1");
            cnt_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt_valid = 1'b0;
        #1;
        chk("rst_cnt_ready", cnt_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_vec_valid", vec_valid, 1'b0);
        chk("rst_vec_o", vec_o, 8'h00);
        chk("rst_cnt_ready2", cnt_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chunk_q.delete();
        bits_q.delete();
        exp_q.delete();
        #1;
        chk("post_rst_cnt_ready", cnt_ready, 1'b1);
    endtask

    task automatic expect_last(input string nm, input logic [7:0] exp);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: %0d vectors pending expected 0", nm, exp_q.size());
        end
        chk(nm, last_vec, exp);
    endtask

    initial begin
        // Reset
        do_reset();

        // All-ones vector, latency and single-cycle pulse
        rdy_mode = 0;
        for (int i = 0; i < VW * NCH; i++) send(8, 32, 1'b0);
        @(negedge clk);
        #2;
        chk("lat_vec_valid", vec_valid, 1'b1);
        @(negedge clk);
        #2;
        chk("pulse_vec_valid", vec_valid, 1'b0);
        expect_last("all_ones", 8'hFF);

        // Alternating thresholds, without and with bubbles
        for (int b = 0; b < 2; b++) begin
            for (int n = 0; n < VW; n++) begin
                send(8, (n % 2) ? 17 : 16, b[0]);
                send(8, (n % 2) ? 17 : 16, b[0]);
                send(0, (n % 2) ? 17 : 16, b[0]);
                send(0, (n % 2) ? 17 : 16, b[0]);
            end
            expect_last(b ? "alt_bubbles" : "alt", 8'h55);
        end

        // Backpressure with input held valid
        rdy_mode = 1;
        for (int n = 0; n < VW; n++)
            for (int c = 0; c < NCH; c++) send(8, (n < 4) ? 32 : 33, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cnt_valid = 1'b1;
            cnt_i = 4'd8;
            thr_i = 6'd32;
            #2;
            chk("bp_cnt_ready", cnt_ready, 1'b0);
            chk("bp_vec_valid", vec_valid, 1'b1);
            chk("bp_vec_o", vec_o, 8'h0F);
        end
        rdy_mode = 0;
        for (int i = 0; i < VW * NCH; i++) send(8, 32, 1'b0);
        expect_last("after_bp", 8'hFF);

        // Reset mid-vector discards partial work
        for (int i = 0; i < 13; i++) send($urandom_range(0, 8), 20, 1'b0);
        do_reset();
        for (int i = 0; i < VW * NCH; i++) send(0, 0, 1'b0);
        expect_last("after_mid_rst", 8'hFF);

        // Threshold bounds
        for (int i = 0; i < VW * NCH; i++) send(8, 33, 1'b0);
        expect_last("thr_over", 8'h00);
        for (int i = 0; i < VW * NCH; i++) send(0, 0, 1'b0);
        expect_last("thr_zero", 8'hFF);

        // Random counts, thresholds, bubbles and backpressure
        rdy_mode = 2;
        for (int i = 0; i < 4 * VW * NCH; i++)
            send($urandom_range(0, 8), $urandom_range(0, 34), 1'b1);
        rdy_mode = 0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        #3;
        chk("random_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
